// File: rtl/register.sv
// rtl/register.sv - APB register file slave with configurable wait states.
// Writes commit on the completing edge only; there is no read-data path.
module register #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        in_access;
    logic        wr_commit;

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    // SETUP here means the setup phase has been seen, so the first access cycle
    // is qualified by state SETUP and the wait counter counts it too.
    assign in_access = psel && penable && (state_q == SETUP || state_q == ACCESS);
    assign pready    = in_access && (wait_q == 4'(WAIT_STATES));
    assign wr_commit = pready && pwrite;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                if (!psel)        state_d = IDLE;
                else if (penable) state_d = pready ? IDLE : ACCESS;
            end
            ACCESS: begin
                if (!psel)         state_d = IDLE;
                else if (!penable) state_d = SETUP;
                else if (pready)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (in_access && !pready) wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_q <= IDLE;
            wait_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            // Addresses beyond NUM_REGS match no entry and are dropped.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_commit && paddr == ADDR_W'(i)) regs[i] <= pwdata;
            end
        end
    end

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - directed bench for register with zero and two wait states.
module tb_register;

    logic       pclk = 1'b0;
    logic       presetn = 1'b1;
    logic       psel0 = 1'b0, psel2 = 1'b0;
    logic       penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic       pready0, pready2;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 pclk = ~pclk;

    register #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(128), .WAIT_STATES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready0)
    );

    register #(.ADDR_W(8), .DATA_W(8), .NUM_REGS(256), .WAIT_STATES(2)) dut2 (
        .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready2)
    );

    a_setup0: assert property (@(posedge pclk) disable iff (presetn)
        (psel0 && !penable && pwrite) |=> (psel0 && penable));
    a_setup2: assert property (@(posedge pclk) disable iff (presetn)
        (psel2 && !penable && pwrite) |=> (psel2 && penable));
    a_stable0: assert property (@(posedge pclk) disable iff (presetn)
        (psel0 && penable && !pready0) |=> (!(psel0 && penable) || ($stable(paddr) && $stable(pwdata))));
    a_stable2: assert property (@(posedge pclk) disable iff (presetn)
        (psel2 && penable && !pready2) |=> (!(psel2 && penable) || ($stable(paddr) && $stable(pwdata))));

    function automatic int nz0();
        int n = 0;
        for (int i = 0; i < 128; i++) if (dut0.regs[i] != 8'h00) n++;
        return n;
    endfunction

    function automatic int nz2();
        int n = 0;
        for (int i = 0; i < 256; i++) if (dut2.regs[i] != 8'h00) n++;
        return n;
    endfunction

    task automatic setup_phase(input bit sel2, input logic wr, input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel0 = !sel2; psel2 = sel2; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d;
    endtask

    task automatic access_phase();
        @(posedge pclk); #1;
        penable = 1'b1;
    endtask

    task automatic idle_bus();
        @(posedge pclk); #1;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        psel0 = 1'b1; psel2 = 1'b1; penable = 1'b1; pwrite = 1'b1;
        #3;
        chk_cnt++; if (pready0 !== 1'b0) $display("FAIL reset_pready0 got=%b exp=0", pready0); else pass_cnt++;
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL reset_pready2 got=%b exp=0", pready2); else pass_cnt++;
        @(posedge pclk); #1;
        chk_cnt++; if (nz0() !== 0) $display("FAIL reset_regs0 got=%0d nonzero exp=0", nz0()); else pass_cnt++;
        chk_cnt++; if (nz2() !== 0) $display("FAIL reset_regs2 got=%0d nonzero exp=0", nz2()); else pass_cnt++;
        psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        presetn = 1'b0;
    endtask

    task automatic test_write_ws0();
        setup_phase(1'b0, 1'b1, 8'h3C, 8'hA5);
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b0) $display("FAIL w0_setup_pready got=%b exp=0", pready0); else pass_cnt++;
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b1) $display("FAIL w0_access_pready got=%b exp=1", pready0); else pass_cnt++;
        chk_cnt++; if (dut0.regs[8'h3C] !== 8'h00) $display("FAIL w0_precommit got=%h exp=00", dut0.regs[8'h3C]); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut0.regs[8'h3C] !== 8'hA5) $display("FAIL w0_commit got=%h exp=a5", dut0.regs[8'h3C]); else pass_cnt++;
        chk_cnt++; if (nz0() !== 1) $display("FAIL w0_others got=%0d nonzero exp=1", nz0()); else pass_cnt++;
        chk_cnt++; if (pready0 !== 1'b0) $display("FAIL w0_idle_pready got=%b exp=0", pready0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        setup_phase(1'b0, 1'b1, 8'h10, 8'h11);
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b1) $display("FAIL b2b_first_pready got=%b exp=1", pready0); else pass_cnt++;
        setup_phase(1'b0, 1'b1, 8'h20, 8'h22);
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b0) $display("FAIL b2b_gap_pready got=%b exp=0", pready0); else pass_cnt++;
        chk_cnt++; if (dut0.regs[8'h10] !== 8'h11) $display("FAIL b2b_first_commit got=%h exp=11", dut0.regs[8'h10]); else pass_cnt++;
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b1) $display("FAIL b2b_second_pready got=%b exp=1", pready0); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut0.regs[8'h20] !== 8'h22) $display("FAIL b2b_second_commit got=%h exp=22", dut0.regs[8'h20]); else pass_cnt++;
        chk_cnt++; if (nz0() !== 3) $display("FAIL b2b_count got=%0d nonzero exp=3", nz0()); else pass_cnt++;
    endtask

    task automatic test_read();
        setup_phase(1'b0, 1'b0, 8'h3C, 8'h00);
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b1) $display("FAIL rd_pready got=%b exp=1", pready0); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut0.regs[8'h3C] !== 8'hA5) $display("FAIL rd_unchanged got=%h exp=a5", dut0.regs[8'h3C]); else pass_cnt++;
        chk_cnt++; if (dut0.regs[8'h00] !== 8'h00) $display("FAIL rd_pwdata_leak got=%h exp=00", dut0.regs[8'h00]); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        setup_phase(1'b0, 1'b1, 8'h90, 8'h5A);
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b1) $display("FAIL oor_pready got=%b exp=1", pready0); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut0.regs[8'h10] !== 8'h11) $display("FAIL oor_alias got=%h exp=11", dut0.regs[8'h10]); else pass_cnt++;
        chk_cnt++; if (nz0() !== 3) $display("FAIL oor_count got=%0d nonzero exp=3", nz0()); else pass_cnt++;
    endtask

    task automatic test_penable_no_psel();
        @(posedge pclk); #1;
        penable = 1'b1; pwrite = 1'b1; paddr = 8'h3C; pwdata = 8'hEE;
        @(negedge pclk);
        chk_cnt++; if (pready0 !== 1'b0) $display("FAIL nosel_pready0 got=%b exp=0", pready0); else pass_cnt++;
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL nosel_pready2 got=%b exp=0", pready2); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut0.regs[8'h3C] !== 8'hA5) $display("FAIL nosel_regs got=%h exp=a5", dut0.regs[8'h3C]); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        setup_phase(1'b1, 1'b1, 8'h05, 8'h7E);
        access_phase();
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL ws_cycle1_pready got=%b exp=0", pready2); else pass_cnt++;
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL ws_cycle2_pready got=%b exp=0", pready2); else pass_cnt++;
        chk_cnt++; if (dut2.regs[8'h05] !== 8'h00) $display("FAIL ws_cycle2_reg got=%h exp=00", dut2.regs[8'h05]); else pass_cnt++;
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b1) $display("FAIL ws_cycle3_pready got=%b exp=1", pready2); else pass_cnt++;
        chk_cnt++; if (dut2.regs[8'h05] !== 8'h00) $display("FAIL ws_cycle3_reg got=%h exp=00", dut2.regs[8'h05]); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut2.regs[8'h05] !== 8'h7E) $display("FAIL ws_commit got=%h exp=7e", dut2.regs[8'h05]); else pass_cnt++;
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL ws_idle_pready got=%b exp=0", pready2); else pass_cnt++;
    endtask

    task automatic test_abort();
        setup_phase(1'b1, 1'b1, 8'h07, 8'h33);
        access_phase();
        @(posedge pclk); #1;
        psel2 = 1'b0;
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL abort_pready got=%b exp=0", pready2); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut2.regs[8'h07] !== 8'h00) $display("FAIL abort_nocommit got=%h exp=00", dut2.regs[8'h07]); else pass_cnt++;
        // A fresh transfer after an abort must see the full wait count again.
        setup_phase(1'b1, 1'b1, 8'h08, 8'h44);
        access_phase();
        @(negedge pclk);
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL abort_restart_wait got=%b exp=0", pready2); else pass_cnt++;
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b1) $display("FAIL abort_restart_done got=%b exp=1", pready2); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut2.regs[8'h08] !== 8'h44) $display("FAIL abort_restart_commit got=%h exp=44", dut2.regs[8'h08]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        setup_phase(1'b1, 1'b1, 8'h40, 8'hFF);
        access_phase();
        @(posedge pclk); #1;
        presetn = 1'b1;
        #1;
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL rstmid_pready got=%b exp=0", pready2); else pass_cnt++;
        chk_cnt++; if (nz2() !== 0) $display("FAIL rstmid_regs2 got=%0d nonzero exp=0", nz2()); else pass_cnt++;
        chk_cnt++; if (nz0() !== 0) $display("FAIL rstmid_regs0 got=%0d nonzero exp=0", nz0()); else pass_cnt++;
        @(posedge pclk); #1;
        presetn = 1'b0;
        @(negedge pclk);
        chk_cnt++; if (pready2 !== 1'b0) $display("FAIL rstrel_pready got=%b exp=0", pready2); else pass_cnt++;
        idle_bus();
        @(negedge pclk);
        chk_cnt++; if (dut2.regs[8'h40] !== 8'h00) $display("FAIL rstrel_nocommit got=%h exp=00", dut2.regs[8'h40]); else pass_cnt++;
        setup_phase(1'b1, 1'b1, 8'h41, 8'h12);
        access_phase();
        repeat (3) @(posedge pclk);
        #1;
        psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk_cnt++; if (dut2.regs[8'h41] !== 8'h12) $display("FAIL rstrel_newxfer got=%h exp=12", dut2.regs[8'h41]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_ws0();
        test_back_to_back();
        test_read();
        test_out_of_range();
        test_penable_no_psel();
        test_wait_states();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter ADDR_W, default 8, width of paddr.
REQ-002 Parameter DATA_W, default 8, width of pwdata and of each storage register.
REQ-003 Parameter NUM_REGS, default 256, number of storage registers; legal range 1..2**ADDR_W.
REQ-004 Parameter WAIT_STATES, default 0, access-phase cycles with pready low before completion; legal range 0..15.
REQ-005 pclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 presetn  input  1  reset, asynchronous, active-high; the block is in reset while presetn=1.
REQ-007 psel  input  1  APB slave select.
REQ-008 penable  input  1  APB access-phase strobe.
REQ-009 pwrite  input  1  1=write transfer, 0=read transfer.
REQ-010 paddr  input  ADDR_W  register address.
REQ-011 pwdata  input  DATA_W  write data.
REQ-012 pready  output  1  transfer-complete handshake.
REQ-013 Storage array regs[0:NUM_REGS-1] of DATA_W bits, hierarchically visible to the bench; there is no read-data port.

Function
REQ-014 FSM states: IDLE, SETUP, ACCESS.
REQ-015 IDLE -> SETUP when psel=1 and penable=0; IDLE holds when psel=0.
REQ-016 SETUP -> ACCESS on the next edge when psel=1 and penable=1; SETUP -> IDLE when psel=0.
REQ-017 ACCESS holds while pready=0; ACCESS with pready=1 -> SETUP if psel=1 and penable=0 next, else IDLE.
REQ-018 Wait counter clears to 0 on entry to ACCESS and increments each ACCESS cycle with pready=0.
REQ-019 pready = psel & penable & (state==ACCESS or SETUP-to-ACCESS cycle) & (wait counter == WAIT_STATES), combinational from registered state.
REQ-020 With WAIT_STATES=0, pready SHALL be 1 in the first cycle with psel=1 and penable=1.
REQ-021 pready SHALL be 0 whenever psel=0 or penable=0.
REQ-022 Write commit: regs[paddr] <= pwdata at the rising pclk edge where psel, penable, pwrite and pready are all 1; exactly one commit per transfer.
REQ-023 Read transfers (pwrite=0) SHALL complete with the same pready timing and SHALL NOT modify any register.
REQ-024 Writes with paddr >= NUM_REGS SHALL complete normally (pready asserted) and SHALL be discarded.
REQ-025 penable=1 with psel=0 SHALL be ignored: no state change, pready=0.
REQ-026 psel dropping during ACCESS before pready SHALL abort the transfer: no commit, FSM -> IDLE, counter cleared.
REQ-027 paddr/pwdata changes during ACCESS wait cycles are the master's error; the block SHALL use the values present at the commit edge.
REQ-028 Back-to-back transfers (ACCESS directly to SETUP) SHALL be supported with no idle cycle.

Reset
REQ-029 While presetn=1: FSM = IDLE, wait counter = 0, every regs entry = 0, pready = 0, independent of pclk.
REQ-030 Reset asserted mid-transfer SHALL abort it with no commit; after reset deasserts, the first SETUP cycle starts a new transfer.
REQ-031 Reset deassertion SHALL take effect at the next rising pclk edge; no commit is allowed on that edge.

Verification
REQ-032 WAIT_STATES=0, write paddr=0x3C pwdata=0xA5 (SETUP, then ACCESS) -> pready=1 in ACCESS cycle; regs[0x3C]=0xA5 after that edge; all other regs remain 0.
REQ-033 Two back-to-back writes (0x10<-0x11, 0x20<-0x22) with no idle cycle -> both committed; pready high for exactly one cycle per transfer.
REQ-034 WAIT_STATES=2, write 0x05<-0x7E -> pready low for 2 ACCESS cycles, high on the 3rd; regs[0x05] unchanged until the 3rd edge.
REQ-035 Read transfer to 0x3C after REQ-032 -> pready=1 in ACCESS; regs[0x3C] stays 0xA5.
REQ-036 Reset asserted during ACCESS of write 0x40<-0xFF with WAIT_STATES=2 -> pready=0 immediately; regs[0x40]=0; all regs 0.
REQ-037 The bench SHALL include these concurrent assertions:
- every write SETUP is followed by ACCESS;
- paddr and pwdata are stable during ACCESS.
